weight_bank: RTL

WEIGHT_BANK -- requirements
Module: weight_bank

---
 rtl/weight_bank_if.sv | 44 ++++
 rtl/weight_bank.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/weight_bank_if.sv
// Request/response bundle for weight_bank.
//   master : drives read/write/update requests, observes w/w_valid/ready/err
//   slave  : the bank itself
// Signals:
//   is_read, w_layer_index, w_row_index          read request + address
//   w, w_valid                                   registered read data + valid pulse
//   is_write, write_layer_index, write_row_index, write_data
//   is_update, layer_index, row_index, dc_dw     gradient update request
//   ready                                        bank accepts requests
//   err                                          pulse on rejected out-of-range request
interface weight_bank_if #(
  parameter int DATA_SIZE = 16,
  parameter int SIZE      = 3
);
  logic                      is_read;
  logic [31:0]               w_layer_index;
  logic [31:0]               w_row_index;
  logic [DATA_SIZE*SIZE-1:0] w;
  logic                      w_valid;
  logic                      is_write;
  logic [31:0]               write_layer_index;
  logic [31:0]               write_row_index;
  logic [DATA_SIZE*SIZE-1:0] write_data;
  logic                      is_update;
  logic [31:0]               layer_index;
  logic [31:0]               row_index;
  logic [DATA_SIZE*SIZE-1:0] dc_dw;
  logic                      ready;
  logic                      err;

  modport master (
    output is_read, w_layer_index, w_row_index,
    output is_write, write_layer_index, write_row_index, write_data,
    output is_update, layer_index, row_index, dc_dw,
    input  w, w_valid, ready, err
  );

  modport slave (
    input  is_read, w_layer_index, w_row_index,
    input  is_write, write_layer_index, write_row_index, write_data,
    input  is_update, layer_index, row_index, dc_dw,
    output w, w_valid, ready, err
  );
endinterface

// File: rtl/weight_bank.sv
// Layered weight storage with read, write and saturating gradient update.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous active-high reset
//   bus    weight_bank_if slave modport (requests in, read data/status out)
// After reset the bank clears one entry per cycle (INIT), then serves
// requests (RUN). Updates run through a two-stage pipeline:
// stage 1 captures address, old row and gradient; stage 2 writes back
// sat(old - (grad >>> SHIFT)) per element.
module weight_bank #(
  parameter int DATA_SIZE  = 16,
  parameter int SIZE       = 3,
  parameter int LAYER_SIZE = 5,
  parameter int ROW_COUNT  = 3,
  parameter int SHIFT      = 4
) (
  input  logic        clk,
  input  logic        reset,
  weight_bank_if.slave bus
);
  localparam int ROW_W   = DATA_SIZE * SIZE;
  localparam int ENTRIES = LAYER_SIZE * ROW_COUNT;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       clr_q, clr_d;
  logic                ready;

  logic [ROW_W-1:0]    mem_q [ENTRIES];

  logic [ROW_W-1:0]    w_q;
  logic                w_valid_q;
  logic                err_q;
  logic                s1_valid_q;
  logic [AW-1:0]       s1_addr_q;
  logic [ROW_W-1:0]    s1_old_q;
  logic [ROW_W-1:0]    s1_grad_q;

  logic                rd_in_range, wr_in_range, up_in_range;
  logic                rd_ok, wr_ok, up_ok, bad_req;
  logic [AW-1:0]       rd_addr, wr_addr, up_addr;
  logic                wb_en;
  logic [ROW_W-1:0]    wb_row;
  logic [ROW_W-1:0]    s1_old_d;

  function automatic logic in_range(input logic [31:0] l, input logic [31:0] r);
    return (l < 32'(LAYER_SIZE)) && (r < 32'(ROW_COUNT));
  endfunction

  function automatic logic [AW-1:0] flat(input logic [31:0] l, input logic [31:0] r);
    return AW'(l * 32'(ROW_COUNT) + r);
  endfunction

  function automatic logic [ROW_W-1:0] apply_grad(input logic [ROW_W-1:0] old_row,
                                                  input logic [ROW_W-1:0] grad_row);
    logic [ROW_W-1:0]            res;
    logic signed [DATA_SIZE-1:0] o, g, sh;
    logic [DATA_SIZE:0]          diff;
    res = '0;
    for (int unsigned k = 0; k < SIZE; k++) begin
      o    = old_row[k*DATA_SIZE +: DATA_SIZE];
      g    = grad_row[k*DATA_SIZE +: DATA_SIZE];
      sh   = g >>> SHIFT;
      // Sign-extend both operands by one bit; a differing top pair means overflow.
      diff = {o[DATA_SIZE-1], o} - {sh[DATA_SIZE-1], sh};
      if (diff[DATA_SIZE] != diff[DATA_SIZE-1])
        res[k*DATA_SIZE +: DATA_SIZE] = diff[DATA_SIZE] ? {1'b1, {(DATA_SIZE-1){1'b0}}}
                                                        : {1'b0, {(DATA_SIZE-1){1'b1}}};
      else
        res[k*DATA_SIZE +: DATA_SIZE] = diff[DATA_SIZE-1:0];
    end
    return res;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Next state / ready
  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    ready   = 1'b0;
    case (state_q)
      INIT: begin
        clr_d = clr_q + AW'(1);
        if (clr_q == AW'(ENTRIES - 1)) begin
          state_d = RUN;
          clr_d   = '0;
        end
      end
      RUN: ready = 1'b1;
      default: state_d = INIT;
    endcase
  end

  // Request decode, hazard resolution
  always_comb begin
    rd_in_range = in_range(bus.w_layer_index, bus.w_row_index);
    wr_in_range = in_range(bus.write_layer_index, bus.write_row_index);
    up_in_range = in_range(bus.layer_index, bus.row_index);
    rd_addr     = flat(bus.w_layer_index, bus.w_row_index);
    wr_addr     = flat(bus.write_layer_index, bus.write_row_index);
    up_addr     = flat(bus.layer_index, bus.row_index);

    rd_ok   = ready && bus.is_read  && rd_in_range;
    wr_ok   = ready && bus.is_write && wr_in_range;
    // A write to the same entry in the same cycle supersedes the update.
    up_ok   = ready && bus.is_update && up_in_range && !(wr_ok && (wr_addr == up_addr));
    bad_req = ready && ((bus.is_read   && !rd_in_range) ||
                        (bus.is_write  && !wr_in_range) ||
                        (bus.is_update && !up_in_range));

    wb_row  = apply_grad(s1_old_q, s1_grad_q);
    // A write landing on the writeback's entry at the same edge wins.
    wb_en   = s1_valid_q && !(wr_ok && (wr_addr == s1_addr_q));

    // Forward the in-flight result so back-to-back updates accumulate.
    s1_old_d = (s1_valid_q && (s1_addr_q == up_addr)) ? wb_row : mem_q[up_addr];
  end

  // Storage: no reset, INIT clears it one entry per cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) begin
        mem_q[clr_q] <= '0;
      end else begin
        if (wb_en) mem_q[s1_addr_q] <= wb_row;
        if (wr_ok) mem_q[wr_addr]   <= bus.write_data;
      end
    end
  end

  // Read port, error pulse and update stage 1
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q        <= '0;
      w_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_old_q   <= '0;
      s1_grad_q  <= '0;
    end else begin
      w_valid_q  <= rd_ok;
      if (rd_ok) w_q <= mem_q[rd_addr];
      err_q      <= bad_req;
      s1_valid_q <= up_ok;
      if (up_ok) begin
        s1_addr_q <= up_addr;
        s1_old_q  <= s1_old_d;
        s1_grad_q <= bus.dc_dw;
      end
    end
  end

  assign bus.w       = w_q;
  assign bus.w_valid = w_valid_q;
  assign bus.ready   = ready;
  assign bus.err     = err_q;
endmodule
